// File: rtl/asrm_bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM states, master indices,
// and the owner reset value.
package asrm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Owner comes out of reset as m1 so that m0 wins the first tie.
  localparam logic ARB_OWNER_RST = ARB_M1;

endpackage

// File: rtl/asrm_rr_pick.sv
// Combinational 2-way round-robin chooser.
// With lock_valid set, only the request of 'last' is eligible.
module asrm_rr_pick
  import asrm_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_valid,
  output logic [1:0] grant,
  output logic       gidx
);

  logic [1:0] elig;

  // Mask requests under lock, then favour the master that did not win last time.
  always_comb begin
    elig = req;
    if (lock_valid) begin
      elig = (last == ARB_M1) ? (req & 2'b10) : (req & 2'b01);
    end
    gidx = last;
    if (elig == 2'b11) begin
      gidx = ~last;
    end else if (elig[1]) begin
      gidx = ARB_M1;
    end else if (elig[0]) begin
      gidx = ARB_M0;
    end
    grant = '0;
    if (elig != 2'b00) begin
      grant = (gidx == ARB_M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/asrm_bus_arbiter.sv
// Two-master round-robin arbiter for a single fixed-latency RAM port.
// One transaction at a time: IDLE -> ACCESS (ram_latency cycles) -> DONE -> IDLE.
// Optional macro ASRM_ARB_LOCK_EN adds m0_lock/m1_lock to hold the bus for the owner.
module asrm_bus_arbiter
  import asrm_bus_arbiter_pkg::*;
#(
  parameter int unsigned wordsize    = 16,
  parameter int unsigned ram_latency = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
`ifdef ASRM_ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic                m0_ack,
  output logic [wordsize-1:0] m0_rdata,
  output logic                m1_ack,
  output logic [wordsize-1:0] m1_rdata,
  output logic [wordsize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data_out,
  output logic                mem_write_en,
  input  logic [wordsize-1:0] mem_data_in,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned CW = (ram_latency > 1) ? $clog2(ram_latency) : 1;

  if (ram_latency < 1) begin : g_bad_latency
    $error("asrm_bus_arbiter: ram_latency must be >= 1");
  end

  arb_state_t          state, state_next;
  logic [CW-1:0]       cnt;
  logic                lat_we;
  logic [wordsize-1:0] cap_q;
  logic                owner_q;
  logic [1:0]          grant;
  logic                gidx;
  logic                grant_any;
  logic                lock_valid;
  logic                done;

`ifdef ASRM_ARB_LOCK_EN
  logic lat_lock;
  logic locked_q;
  assign lock_valid = locked_q;
`else
  assign lock_valid = 1'b0;
`endif

  asrm_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last       (owner_q),
    .lock_valid (lock_valid),
    .grant      (grant),
    .gidx       (gidx)
  );

  assign grant_any = |grant;

  // Next-state: arbitration only in IDLE, counter decides the end of ACCESS.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:   if (grant_any) state_next = ARB_ACCESS;
      ARB_ACCESS: if (cnt == '0) state_next = ARB_DONE;
      ARB_DONE:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // Output decode from registered state; rdata is zero for writes and non-owners.
  always_comb begin
    done         = (state == ARB_DONE);
    busy         = (state != ARB_IDLE);
    mem_write_en = (state == ARB_ACCESS) && lat_we;
    m0_ack       = done && (owner_q == ARB_M0);
    m1_ack       = done && (owner_q == ARB_M1);
    m0_rdata     = (m0_ack && !lat_we) ? cap_q : '0;
    m1_rdata     = (m1_ack && !lat_we) ? cap_q : '0;
    owner        = owner_q;
  end

  // State, latched transaction, latency counter and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      owner_q      <= ARB_OWNER_RST;
      lat_we       <= 1'b0;
      cnt          <= '0;
      cap_q        <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
`ifdef ASRM_ARB_LOCK_EN
      lat_lock     <= 1'b0;
      locked_q     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      unique case (state)
        ARB_IDLE: begin
          if (grant_any) begin
            owner_q      <= gidx;
            lat_we       <= (gidx == ARB_M1) ? m1_we    : m0_we;
            mem_addr     <= (gidx == ARB_M1) ? m1_addr  : m0_addr;
            mem_data_out <= (gidx == ARB_M1) ? m1_wdata : m0_wdata;
            cnt          <= CW'(ram_latency - 1);
`ifdef ASRM_ARB_LOCK_EN
            lat_lock     <= (gidx == ARB_M1) ? m1_lock  : m0_lock;
`endif
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) cap_q <= mem_data_in;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ARB_DONE: begin
`ifdef ASRM_ARB_LOCK_EN
          // Lock state only changes when a transaction completes.
          locked_q <= lat_lock;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asrm_bus_arbiter.sv
// Self-checking bench for asrm_bus_arbiter: two instances (ram_latency 1 and 3),
// a cycle-timed transaction model per instance, and directed scenarios.
module tb_asrm_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        lock;
  } txn_t;

  typedef struct {
    int          cyc;
    int          m;
    logic [15:0] rdata;
    logic        own;
  } ack_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic        rst [2];
  logic        req [2][2];
  logic        we [2][2];
  logic [15:0] addr [2][2];
  logic [15:0] wdata [2][2];
`ifdef ASRM_ARB_LOCK_EN
  logic        lock [2][2];
`endif
  logic        ack [2][2];
  logic [15:0] rdata [2][2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_dout [2];
  logic [15:0] mem_din [2];
  logic        mem_we [2];
  logic        busy [2];
  logic        owner [2];

  txn_t     mq [4][$];
  int       rise_cyc [4];
  ack_rec_t alog [2][$];
  int       both_ack [2];
  int       we_cnt [2];

  function automatic logic [15:0] pat(input logic [7:0] a);
    return 16'h1224 + {8'h00, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 1 : 3;

    asrm_bus_arbiter #(.wordsize(16), .ram_latency(L)) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .m0_req       (req[g][0]),
      .m0_we        (we[g][0]),
      .m0_addr      (addr[g][0]),
      .m0_wdata     (wdata[g][0]),
      .m1_req       (req[g][1]),
      .m1_we        (we[g][1]),
      .m1_addr      (addr[g][1]),
      .m1_wdata     (wdata[g][1]),
`ifdef ASRM_ARB_LOCK_EN
      .m0_lock      (lock[g][0]),
      .m1_lock      (lock[g][1]),
`endif
      .m0_ack       (ack[g][0]),
      .m0_rdata     (rdata[g][0]),
      .m1_ack       (ack[g][1]),
      .m1_rdata     (rdata[g][1]),
      .mem_addr     (mem_addr[g]),
      .mem_data_out (mem_dout[g]),
      .mem_write_en (mem_we[g]),
      .mem_data_in  (mem_din[g]),
      .busy         (busy[g]),
      .owner        (owner[g])
    );

    // RAM environment: unwritten locations read back a fixed pattern.
    bit [15:0]  ram [256];
    bit [255:0] wv;
    assign mem_din[g] = wv[mem_addr[g][7:0]] ? ram[mem_addr[g][7:0]] : pat(mem_addr[g][7:0]);
    always @(posedge clk) begin
      if (mem_we[g]) begin
        ram[mem_addr[g][7:0]] <= mem_dout[g];
        wv[mem_addr[g][7:0]]  <= 1'b1;
      end
    end

    // Master agents: present queued transactions, hold req until ack.
    for (genvar gm = 0; gm < 2; gm++) begin : g_m
      always @(negedge clk) begin
        if (rst[g] !== 1'b0) begin
          req[g][gm]   = 1'b0;
          we[g][gm]    = 1'b0;
          addr[g][gm]  = '0;
          wdata[g][gm] = '0;
`ifdef ASRM_ARB_LOCK_EN
          lock[g][gm]  = 1'b0;
`endif
          mq[g*2+gm].delete();
        end else begin
          if (req[g][gm] && ack[g][gm]) begin
            void'(mq[g*2+gm].pop_front());
            req[g][gm] = 1'b0;
          end
          if (!req[g][gm] && mq[g*2+gm].size() > 0) begin
            we[g][gm]    = mq[g*2+gm][0].we;
            addr[g][gm]  = mq[g*2+gm][0].addr;
            wdata[g][gm] = mq[g*2+gm][0].wdata;
`ifdef ASRM_ARB_LOCK_EN
            lock[g][gm]  = mq[g*2+gm][0].lock;
`endif
            req[g][gm]   = 1'b1;
            rise_cyc[g*2+gm] = cyc;
          end
        end
      end
    end

    // Model: t counts cycles since grant (0 = idle, 1..L = access, L+1 = ack).
    int          t = 0;
    logic        mown, mlock, cur_m;
    txn_t        cur;
    logic [15:0] ma, md, cap;
    bit [15:0]   rram [256];
    bit [255:0]  rwv;

    always @(posedge clk) begin
      logic r0, r1, w;
      if (t >= 1 && t <= int'(L) && cur.we) begin
        rram[cur.addr[7:0]] = cur.wdata;
        rwv[cur.addr[7:0]]  = 1'b1;
      end
      if (rst[g] !== 1'b0) begin
        t = 0; mown = 1'b1; mlock = 1'b0; ma = '0; md = '0; cap = '0;
      end else if (t == 0) begin
        r0 = req[g][0];
        r1 = req[g][1];
        if (mlock) begin
          if (mown) r0 = 1'b0;
          else      r1 = 1'b0;
        end
        if (r0 || r1) begin
          w = (r0 && r1) ? ~mown : r1;
          cur.we    = we[g][w];
          cur.addr  = addr[g][w];
          cur.wdata = wdata[g][w];
`ifdef ASRM_ARB_LOCK_EN
          cur.lock  = lock[g][w];
`else
          cur.lock  = 1'b0;
`endif
          cur_m = w; mown = w; ma = cur.addr; md = cur.wdata; t = 1;
        end
      end else if (t <= int'(L)) begin
        if (t == int'(L))
          cap = cur.we ? 16'h0000 : (rwv[cur.addr[7:0]] ? rram[cur.addr[7:0]] : pat(cur.addr[7:0]));
        t++;
      end else begin
        mlock = cur.lock;
        t = 0;
      end
    end

    // Compare every output every cycle against the model.
    always @(negedge clk) begin
      logic ea0, ea1, ewe;
      if (chk_en) begin
        ea0 = (t == int'(L) + 1) && (cur_m == 1'b0);
        ea1 = (t == int'(L) + 1) && (cur_m == 1'b1);
        ewe = (t >= 1) && (t <= int'(L)) && cur.we;
        chk($sformatf("i%0d_busy", g),     32'(busy[g]),    32'(t != 0));
        chk($sformatf("i%0d_mem_we", g),   32'(mem_we[g]),  32'(ewe));
        chk($sformatf("i%0d_mem_addr", g), 32'(mem_addr[g]), 32'(ma));
        chk($sformatf("i%0d_mem_dout", g), 32'(mem_dout[g]), 32'(md));
        chk($sformatf("i%0d_owner", g),    32'(owner[g]),   32'(mown));
        chk($sformatf("i%0d_ack0", g),     32'(ack[g][0]),  32'(ea0));
        chk($sformatf("i%0d_ack1", g),     32'(ack[g][1]),  32'(ea1));
        chk($sformatf("i%0d_rdata0", g),   32'(rdata[g][0]), ea0 ? 32'(cap) : 32'h0);
        chk($sformatf("i%0d_rdata1", g),   32'(rdata[g][1]), ea1 ? 32'(cap) : 32'h0);
      end
    end

    // Ack log and event counters for the directed scenarios.
    always @(negedge clk) begin
      ack_rec_t r;
      if (mem_we[g]) we_cnt[g]++;
      if (ack[g][0] && ack[g][1]) both_ack[g]++;
      for (int m = 0; m < 2; m++) begin
        if (ack[g][m]) begin
          r.cyc = cyc; r.m = m; r.rdata = rdata[g][m]; r.own = owner[g];
          alog[g].push_back(r);
        end
      end
    end
  end

  task automatic push(input int d, input int m, input logic w, input logic [15:0] a,
                      input logic [15:0] wd, input logic lk);
    txn_t x;
    x.we = w; x.addr = a; x.wdata = wd; x.lock = lk;
    mq[d*2+m].push_back(x);
  endtask

  task automatic wait_idle(input int d);
    for (int n = 0; n <= 300; n++) begin
      @(negedge clk);
      if (mq[d*2].size() == 0 && mq[d*2+1].size() == 0 &&
          !req[d][0] && !req[d][1] && !busy[d]) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_reset(input int d);
    @(posedge clk); #1 rst[d] = 1'b1;
    @(posedge clk); #1 rst[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0; chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_owner", 32'(owner[d]), 32'd1);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr[d]), 32'd0);
      chk("rst_mem_we", 32'(mem_we[d]), 32'd0);
      chk("rst_acks", {30'd0, ack[d][1], ack[d][0]}, 32'd0);
    end

    // 1: single read, latency 1
    alog[0].delete();
    @(posedge clk); #1 push(0, 0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    for (int n = 0; n < 20 && !busy[0]; n++) @(negedge clk);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr[0]), 32'h0010);
    chk("t1_mem_we", 32'(mem_we[0]), 32'd0);
    wait_idle(0);
    chk("t1_nacks", alog[0].size(), 32'd1);
    if (alog[0].size() == 1) begin
      chk("t1_master", alog[0][0].m, 32'd0);
      chk("t1_rdata", 32'(alog[0][0].rdata), 32'h1234);
      chk("t1_latency", alog[0][0].cyc - rise_cyc[0], 32'd2);
    end

    // 2: tie from reset, m0 writes then m1 reads the same word
    pulse_reset(0);
    alog[0].delete();
    base = we_cnt[0];
    push(0, 0, 1'b1, 16'h0020, 16'hBEEF, 1'b0);
    push(0, 1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    wait_idle(0);
    chk("t2_nacks", alog[0].size(), 32'd2);
    if (alog[0].size() == 2) begin
      chk("t2_first", alog[0][0].m, 32'd0);
      chk("t2_owner_first", 32'(alog[0][0].own), 32'd0);
      chk("t2_second", alog[0][1].m, 32'd1);
      chk("t2_owner_second", 32'(alog[0][1].own), 32'd1);
      chk("t2_rdata", 32'(alog[0][1].rdata), 32'hBEEF);
    end
    chk("t2_we_cycles", we_cnt[0] - base, 32'd1);

    // 3: both masters hold req for 6 transactions
    alog[0].delete();
    base = both_ack[0];
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 1'b0, 16'h0030 + 16'(i), 16'h0000, 1'b0);
      push(0, 1, 1'b0, 16'h0038 + 16'(i), 16'h0000, 1'b0);
    end
    wait_idle(0);
    chk("t3_nacks", alog[0].size(), 32'd6);
    if (alog[0].size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t3_order%0d", i), alog[0][i].m, i % 2);
        if (i > 0) chk($sformatf("t3_spacing%0d", i), alog[0][i].cyc - alog[0][i-1].cyc, 32'd3);
      end
    end
    chk("t3_both_acks", both_ack[0] - base, 32'd0);

    // 4: latency 3; m1 read, m0 write arrives during ACCESS
    alog[1].delete();
    base = we_cnt[1];
    @(posedge clk); #1 push(1, 1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 push(1, 0, 1'b1, 16'h0041, 16'h4141, 1'b0);
    wait_idle(1);
    chk("t4_nacks", alog[1].size(), 32'd2);
    if (alog[1].size() == 2) begin
      chk("t4_first", alog[1][0].m, 32'd1);
      chk("t4_latency", alog[1][0].cyc - rise_cyc[3], 32'd4);
      chk("t4_rdata", 32'(alog[1][0].rdata), 32'h1264);
      chk("t4_second", alog[1][1].m, 32'd0);
      chk("t4_spacing", alog[1][1].cyc - alog[1][0].cyc, 32'd5);
    end
    chk("t4_we_cycles", we_cnt[1] - base, 32'd3);

    // 5: reset during ACCESS of a write, then a fresh read
    alog[1].delete();
    @(posedge clk); #1 push(1, 0, 1'b1, 16'h0050, 16'hA5A5, 1'b0);
    for (int n = 0; n < 20 && !mem_we[1]; n++) @(negedge clk);
    chk("t5_in_access", 32'(mem_we[1]), 32'd1);
    @(posedge clk); #1 rst[1] = 1'b1;
    @(posedge clk); #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy[1]), 32'd0);
    chk("t5_mem_we", 32'(mem_we[1]), 32'd0);
    chk("t5_acks", {30'd0, ack[1][1], ack[1][0]}, 32'd0);
    repeat (6) @(negedge clk);
    chk("t5_no_ack", alog[1].size(), 32'd0);
    @(posedge clk); #1 push(1, 1, 1'b0, 16'h0050, 16'h0000, 1'b0);
    wait_idle(1);
    chk("t5_nacks", alog[1].size(), 32'd1);
    if (alog[1].size() == 1) begin
      chk("t5_master", alog[1][0].m, 32'd1);
      chk("t5_rdata", 32'(alog[1][0].rdata), 32'hA5A5);
    end

`ifdef ASRM_ARB_LOCK_EN
    // 6: m1 locked burst keeps m0 waiting until the unlocked write completes
    alog[0].delete();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      push(0, 1, 1'b1, 16'h0060 + 16'(i), 16'h6000 + 16'(i), (i < 3) ? 1'b1 : 1'b0);
    @(posedge clk); #1 push(0, 0, 1'b0, 16'h0061, 16'h0000, 1'b0);
    wait_idle(0);
    chk("t6_nacks", alog[0].size(), 32'd5);
    if (alog[0].size() == 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t6_m1_%0d", i), alog[0][i].m, 32'd1);
      chk("t6_m0_last", alog[0][4].m, 32'd0);
      chk("t6_rdata", 32'(alog[0][4].rdata), 32'h6001);
    end
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
